// File: rtl/shift_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : shift_unit_pipe
// Purpose  : Pipelined barrel shifter (SRL/SLL/SRA/ROR) with valid/ready
//            handshake, global stall, and a pass-through tag.
// Revision : 1.0
// ============================================================================
module shift_unit_pipe #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_STAGE = 2,
    parameter int TAG_W          = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   in_amt,
    input  logic [1:0]                 in_op,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam int LAT = (SHW + BITS_PER_STAGE - 1) / BITS_PER_STAGE;
    // Control fields only need carrying between stages, never out of the last one.
    localparam int NC  = (LAT > 1) ? LAT - 1 : 1;

    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // Amount bits owned by stage k, clipped at the top of the amount field.
    function automatic logic [SHW-1:0] stage_mask(input int k);
        logic [SHW-1:0] m;
        m = '0;
        for (int j = 0; j < SHW; j++) begin
            if (j >= k * BITS_PER_STAGE && j < (k + 1) * BITS_PER_STAGE) begin
                m[j] = 1'b1;
            end
        end
        return m;
    endfunction

    // Right shifts run through a double-width word whose upper half is the fill.
    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0] d,
        input logic [SHW-1:0]   sh,
        input logic [1:0]       op,
        input logic             sign
    );
        logic [2*WIDTH-1:0] t;
        logic [WIDTH-1:0]   r;
        if (op == OP_SRA) begin
            t = {{WIDTH{sign}}, d};
        end else if (op == OP_ROR) begin
            t = {d, d};
        end else begin
            t = {{WIDTH{1'b0}}, d};
        end
        t = t >> sh;
        r = (op == OP_SLL) ? (d << sh) : t[WIDTH-1:0];
        return r;
    endfunction

    logic [WIDTH-1:0] r_data [LAT];
    logic [TAG_W-1:0] r_tag  [LAT];
    logic [LAT-1:0]   r_vld;
    logic             r_zero;
    logic [SHW-1:0]   r_amt  [NC];
    logic [1:0]       r_op   [NC];
    logic [NC-1:0]    r_sign;

    logic [WIDTH-1:0] w_din  [LAT];
    logic [SHW-1:0]   w_amt  [LAT];
    logic [1:0]       w_op   [LAT];
    logic [LAT-1:0]   w_sign;
    logic [TAG_W-1:0] w_tin  [LAT];
    logic [LAT-1:0]   w_vin;
    logic [WIDTH-1:0] w_res  [LAT];
    logic             w_adv;

    assign w_adv     = out_ready | ~r_vld[LAT-1];
    assign in_ready  = w_adv;
    assign out_valid = r_vld[LAT-1];
    assign out_data  = r_data[LAT-1];
    assign out_tag   = r_tag[LAT-1];
    assign out_zero  = r_zero;

    for (genvar k = 0; k < LAT; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_din[k]  = in_data;
            assign w_amt[k]  = in_amt;
            assign w_op[k]   = in_op;
            assign w_sign[k] = in_data[WIDTH-1];
            assign w_tin[k]  = in_tag;
            assign w_vin[k]  = in_valid;
        end else begin : g_body
            assign w_din[k]  = r_data[k-1];
            assign w_amt[k]  = r_amt[k-1];
            assign w_op[k]   = r_op[k-1];
            assign w_sign[k] = r_sign[k-1];
            assign w_tin[k]  = r_tag[k-1];
            assign w_vin[k]  = r_vld[k-1];
        end
        assign w_res[k] = stage_shift(w_din[k], w_amt[k] & stage_mask(k), w_op[k], w_sign[k]);
    end

    // Whole pipeline moves together; invalid slots advance as bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= '0;
            r_zero <= 1'b0;
            for (int k = 0; k < LAT; k++) begin
                r_data[k] <= '0;
                r_tag[k]  <= '0;
            end
        end else if (w_adv) begin
            r_vld  <= w_vin;
            r_zero <= (w_res[LAT-1] == '0);
            for (int k = 0; k < LAT; k++) begin
                r_data[k] <= w_res[k];
                r_tag[k]  <= w_tin[k];
            end
            for (int k = 0; k < LAT - 1; k++) begin
                r_amt[k]  <= w_amt[k];
                r_op[k]   <= w_op[k];
                r_sign[k] <= w_sign[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_unit_pipe
// Purpose  : Self-checking bench for shift_unit_pipe in three configurations.
// Revision : 1.0
// ============================================================================
module tb_shift_unit_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] s_data;
    logic [5:0]  s_amt;
    logic [1:0]  s_op;
    logic [3:0]  s_tag;
    logic        out_ready;
    logic [2:0]  v;

    logic        rdy0, ov0, oz0, rdy1, ov1, oz1, rdy2, ov2, oz2;
    logic [31:0] od0;
    logic [7:0]  od1;
    logic [63:0] od2;
    logic [3:0]  ot0, ot1, ot2;

    int          cur;
    logic        m_rdy, m_ov, m_oz;
    logic [63:0] m_od;
    logic [3:0]  m_ot;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] d;
        logic [3:0]  t;
        int          c;
    } exp_t;

    shift_unit_pipe #(.WIDTH(32), .BITS_PER_STAGE(2), .TAG_W(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v[0]), .in_ready(rdy0),
        .in_data(s_data[31:0]), .in_amt(s_amt[4:0]), .in_op(s_op), .in_tag(s_tag),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_tag(ot0), .out_zero(oz0)
    );
    shift_unit_pipe #(.WIDTH(8), .BITS_PER_STAGE(1), .TAG_W(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v[1]), .in_ready(rdy1),
        .in_data(s_data[7:0]), .in_amt(s_amt[2:0]), .in_op(s_op), .in_tag(s_tag),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_tag(ot1), .out_zero(oz1)
    );
    shift_unit_pipe #(.WIDTH(64), .BITS_PER_STAGE(3), .TAG_W(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v[2]), .in_ready(rdy2),
        .in_data(s_data), .in_amt(s_amt), .in_op(s_op), .in_tag(s_tag),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_tag(ot2), .out_zero(oz2)
    );

    always_comb begin
        m_rdy = rdy0; m_ov = ov0; m_oz = oz0; m_od = {32'd0, od0}; m_ot = ot0;
        if (cur == 1) begin
            m_rdy = rdy1; m_ov = ov1; m_oz = oz1; m_od = {56'd0, od1}; m_ot = ot1;
        end else if (cur == 2) begin
            m_rdy = rdy2; m_ov = ov2; m_oz = oz2; m_od = od2; m_ot = ot2;
        end
    end

    function automatic int width_of(input int c);
        return (c == 1) ? 8 : (c == 2) ? 64 : 32;
    endfunction

    function automatic int lat_of(input int c);
        return (c == 2) ? 2 : 3;
    endfunction

    function automatic logic [63:0] mask_of(input int w);
        logic [63:0] m;
        m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return m;
    endfunction

    // Bit-index view of each operation: output bit i takes input bit i+a (right) or i-a (left).
    function automatic logic [63:0] ref_shift(input logic [63:0] d, input int a,
                                              input logic [1:0] op, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (op)
                2'b00:   r[i] = (i + a < w) ? d[i + a] : 1'b0;
                2'b01:   r[i] = (i >= a) ? d[i - a] : 1'b0;
                2'b10:   r[i] = (i + a < w) ? d[i + a] : d[w - 1];
                default: r[i] = d[(i + a) % w];
            endcase
        end
        return r;
    endfunction

    // Issue one request with out_ready high and report what came out and when.
    task automatic run_one(input int c, input logic [63:0] d, input int a, input logic [1:0] op,
                           input logic [3:0] tag, output logic [63:0] od, output logic [3:0] ot,
                           output logic oz, output int lat);
        int n;
        cur = c; s_data = d; s_amt = 6'(a); s_op = op; s_tag = tag; out_ready = 1'b1; v[c] = 1'b1;
        @(posedge clk); #1;
        v[c] = 1'b0;
        n = 1;
        #1;
        while (!m_ov && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        lat = m_ov ? n : -1;
        od = m_od; ot = m_ot; oz = m_oz;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b0; v = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cur = c;
            #1;
            checks++; if (m_ov !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d] got %b exp 0", c, m_ov); end
            checks++; if (m_od !== 64'd0) begin errors++; $display("FAIL reset_data[%0d] got %h exp 0", c, m_od); end
            checks++; if (m_ot !== 4'd0) begin errors++; $display("FAIL reset_tag[%0d] got %h exp 0", c, m_ot); end
            checks++; if (m_oz !== 1'b0) begin errors++; $display("FAIL reset_zero[%0d] got %b exp 0", c, m_oz); end
            checks++; if (m_rdy !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d] got %b exp 1", c, m_rdy); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] td [3] = '{32'h80000001, 32'h80000000, 32'h80000000};
        int          ta [3] = '{31, 4, 4};
        logic [1:0]  to [3] = '{2'b00, 2'b10, 2'b00};
        logic [31:0] te [3] = '{32'h00000001, 32'hF8000000, 32'h08000000};
        logic [63:0] od; logic [3:0] ot; logic oz; int lat;
        for (int i = 0; i < 3; i++) begin
            run_one(0, {32'd0, td[i]}, ta[i], to[i], 4'(i), od, ot, oz, lat);
            checks++; if (od !== {32'd0, te[i]}) begin errors++; $display("FAIL basic_data[%0d] got %h exp %h", i, od, te[i]); end
            checks++; if (lat != 3) begin errors++; $display("FAIL basic_latency[%0d] got %0d exp 3", i, lat); end
            checks++; if (oz !== 1'b0) begin errors++; $display("FAIL basic_zero[%0d] got %b exp 0", i, oz); end
            checks++; if (ot !== 4'(i)) begin errors++; $display("FAIL basic_tag[%0d] got %h exp %h", i, ot, i); end
        end
    endtask

    task automatic test_ror_sll();
        logic [31:0] td [4] = '{32'h000000F1, 32'h00000001, 32'hFFFFFFFF, 32'h0000000F};
        int          ta [4] = '{4, 31, 0, 4};
        logic [1:0]  to [4] = '{2'b11, 2'b01, 2'b01, 2'b00};
        logic [31:0] te [4] = '{32'h1000000F, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        logic        tz [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [63:0] od; logic [3:0] ot; logic oz; int lat;
        for (int i = 0; i < 4; i++) begin
            run_one(0, {32'd0, td[i]}, ta[i], to[i], 4'(i + 8), od, ot, oz, lat);
            checks++; if (od !== {32'd0, te[i]}) begin errors++; $display("FAIL rorsll_data[%0d] got %h exp %h", i, od, te[i]); end
            checks++; if (oz !== tz[i]) begin errors++; $display("FAIL rorsll_zero[%0d] got %b exp %b", i, oz, tz[i]); end
            checks++; if (lat != 3) begin errors++; $display("FAIL rorsll_latency[%0d] got %0d exp 3", i, lat); end
        end
    endtask

    task automatic test_stream();
        exp_t q[$]; exp_t e;
        int first = -1, last = -1, got = 0;
        cur = 0; out_ready = 1'b1;
        for (int n = 0; n < 25; n++) begin
            v[0] = (n < 8);
            s_data = {32'd0, $urandom}; s_amt = 6'($urandom_range(31)); s_op = 2'($urandom); s_tag = 4'(n);
            #1;
            if (m_ov) begin
                if (first < 0) first = n;
                last = n;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    checks++; if (m_ot !== e.t) begin errors++; $display("FAIL stream_tag got %h exp %h", m_ot, e.t); end
                    checks++; if (m_od !== e.d) begin errors++; $display("FAIL stream_data got %h exp %h", m_od, e.d); end
                end
                got++;
            end
            if (v[0] && m_rdy) begin
                e.d = ref_shift(s_data, int'(s_amt), s_op, 32); e.t = s_tag; e.c = n;
                q.push_back(e);
            end
            @(posedge clk); #1;
        end
        v[0] = 1'b0;
        checks++; if (first != 3) begin errors++; $display("FAIL stream_first got %0d exp 3", first); end
        checks++; if (last != 10) begin errors++; $display("FAIL stream_last got %0d exp 10", last); end
        checks++; if (got != 8) begin errors++; $display("FAIL stream_count got %0d exp 8", got); end
    endtask

    task automatic test_back_pressure();
        exp_t q[$]; exp_t e;
        int stall = -1, got = 0, sent = 0, n = 0;
        cur = 0;
        while (got < 4 && n < 40) begin
            out_ready = !(stall >= 0 && n > stall && n <= stall + 5);
            v[0] = (sent < 4);
            s_data = {32'd0, $urandom}; s_amt = 6'($urandom_range(31)); s_op = 2'($urandom); s_tag = 4'(sent + 4);
            #1;
            if (m_ov && stall < 0) stall = n;
            if (!out_ready) begin
                checks++; if (m_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", m_rdy); end
                checks++; if (m_ov !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", m_ov); end
                if (q.size() > 0) begin
                    checks++; if (m_od !== q[0].d) begin errors++; $display("FAIL bp_hold_data got %h exp %h", m_od, q[0].d); end
                    checks++; if (m_ot !== q[0].t) begin errors++; $display("FAIL bp_hold_tag got %h exp %h", m_ot, q[0].t); end
                end
            end
            if (m_ov && out_ready) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    checks++; if (m_od !== e.d) begin errors++; $display("FAIL bp_data got %h exp %h", m_od, e.d); end
                    checks++; if (m_ot !== e.t) begin errors++; $display("FAIL bp_tag got %h exp %h", m_ot, e.t); end
                end
                got++;
            end
            if (v[0] && m_rdy) begin
                e.d = ref_shift(s_data, int'(s_amt), s_op, 32); e.t = s_tag; e.c = n;
                q.push_back(e); sent++;
            end
            @(posedge clk); #1;
            n++;
        end
        v[0] = 1'b0; out_ready = 1'b1;
        repeat (4) begin
            #1;
            if (m_ov) got++;
            @(posedge clk); #1;
        end
        checks++; if (got != 4 || q.size() != 0) begin errors++; $display("FAIL bp_count got %0d left %0d exp 4 left 0", got, q.size()); end
    endtask

    task automatic test_reset_mid();
        cur = 0; out_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            v[0] = 1'b1; s_data = {32'd0, $urandom | 32'h1}; s_amt = 6'd0; s_op = 2'b00; s_tag = 4'(n + 1);
            @(posedge clk); #1;
        end
        v[0] = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (m_ov !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", m_ov); end
        checks++; if (m_od !== 64'd0) begin errors++; $display("FAIL rmid_data got %h exp 0", m_od); end
        checks++; if (m_rdy !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", m_rdy); end
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #2;
            checks++; if (m_ov !== 1'b0) begin errors++; $display("FAIL rmid_ghost[%0d] got %b exp 0", n, m_ov); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep(input int c, input int n_ops);
        exp_t q[$]; exp_t e;
        int w, sent = 0, got = 0, cyc = 0, lat;
        logic [63:0] mask, d, od; logic [3:0] ot; logic oz; logic [1:0] op; int a;
        w = width_of(c); mask = mask_of(w);
        d = {$urandom, $urandom} & mask; a = $urandom_range(w - 1); op = 2'($urandom);
        run_one(c, d, a, op, 4'hA, od, ot, oz, lat);
        checks++; if (lat != lat_of(c)) begin errors++; $display("FAIL sweep%0d_latency got %0d exp %0d", c, lat, lat_of(c)); end
        checks++; if (od !== ref_shift(d, a, op, w)) begin errors++; $display("FAIL sweep%0d_first got %h exp %h", c, od, ref_shift(d, a, op, w)); end
        cur = c;
        while (got < n_ops && cyc < 20 * n_ops) begin
            v[c] = (sent < n_ops) && ($urandom_range(3) != 0);
            s_data = {$urandom, $urandom} & mask; s_amt = 6'($urandom_range(w - 1));
            s_op = 2'($urandom); s_tag = 4'($urandom);
            out_ready = ($urandom_range(3) != 0);
            #1;
            checks++; if (m_rdy !== (out_ready | ~m_ov)) begin errors++; $display("FAIL sweep%0d_ready got %b exp %b", c, m_rdy, out_ready | ~m_ov); end
            if (m_ov && out_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++; $display("FAIL sweep%0d_spurious got %h exp none", c, m_od);
                end else begin
                    e = q.pop_front();
                    checks++; if (m_od !== e.d) begin errors++; $display("FAIL sweep%0d_data got %h exp %h", c, m_od, e.d); end
                    checks++; if (m_ot !== e.t) begin errors++; $display("FAIL sweep%0d_tag got %h exp %h", c, m_ot, e.t); end
                    checks++; if (m_oz !== (e.d == 64'd0)) begin errors++; $display("FAIL sweep%0d_zero got %b exp %b", c, m_oz, e.d == 64'd0); end
                end
                got++;
            end
            if (v[c] && m_rdy) begin
                e.d = ref_shift(s_data, int'(s_amt), s_op, w); e.t = s_tag; e.c = cyc;
                q.push_back(e); sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        v[c] = 1'b0;
        checks++; if (got != n_ops || q.size() != 0) begin errors++; $display("FAIL sweep%0d_count got %0d left %0d exp %0d", c, got, q.size(), n_ops); end
    endtask

    initial begin
        rst = 1'b1; v = '0; out_ready = 1'b0; cur = 0;
        s_data = '0; s_amt = '0; s_op = '0; s_tag = '0;
        test_reset();
        test_basic();
        test_ror_sll();
        test_stream();
        test_back_pressure();
        test_reset_mid();
        test_sweep(1, 1000);
        test_sweep(2, 1000);
        test_sweep(0, 500);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
Parametrised, pipelined barrel shifter for the datapath ALU. It supports logical right, logical left, arithmetic right and rotate right on a WIDTH-bit operand. The shift is split across registered stages, and a valid/ready handshake on both sides allows back-pressure. A user tag travels with each operation so that downstream logic can match results to requests.

Parameters:
WIDTH, 32, operand width; must be a power of 2 and at least 2.
BITS_PER_STAGE, 2, shift-amount bits resolved per pipeline stage; 1..SHW.
TAG_W, 4, width of the sideband tag; at least 1.
(localparam) SHW = $clog2(WIDTH); LAT = ceil(SHW / BITS_PER_STAGE), the pipeline depth in cycles.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  request present.
in_ready  output  1  unit can accept a request this cycle.
in_data  input  WIDTH  operand.
in_amt  input  SHW  shift amount, 0..WIDTH-1.
in_op  input  2  operation: 00 SRL, 01 SLL, 10 SRA, 11 ROR.
in_tag  input  TAG_W  sideband tag, passed through unchanged.
out_valid  output  1  result present.
out_ready  input  1  consumer accepts the result.
out_data  output  WIDTH  shifted result.
out_tag  output  TAG_W  tag of the result.
out_zero  output  1  high when out_data == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all stage valid bits 0 (so out_valid=0), out_data=0, out_tag=0, out_zero=0.
- Reset mid-operation: every in-flight operation is dropped with no output. in_ready=1 in the first cycle after rst deasserts.
- Advance condition: adv = out_ready | ~out_valid.
  - The whole pipeline shifts by one stage on a cycle where adv=1.
  - in_ready = adv, combinational from out_ready and the last-stage valid.
  - A request is accepted on a cycle with in_valid & in_ready.
- Bubbles are carried, not collapsed. This gives simple global stall semantics.
- Latency: an accepted request appears on out_* exactly LAT cycles later if adv stays high. Default WIDTH=32, B=2 gives LAT=3.
- Throughput: one result per cycle with no stalls.
- Stalled output: while out_valid=1 and out_ready=0, out_data, out_tag and out_zero hold stable and no stage changes.
- Stage k (0..LAT-1) resolves amount bits [k*B +: B], clipped at SHW-1.
  - It shifts or rotates its input by (those bits) << (k*B) positions.
  - Each stage registers data, remaining amount bits, op, tag and valid.
- Ops:
  - SRL: zero fill at the MSB end.
  - SLL: zero fill at the LSB end.
  - SRA: fill with the sign bit of the original operand; each stage carries the sign.
  - ROR: bits leaving the LSB re-enter at the MSB.
- in_amt = 0 returns in_data unchanged for all ops. in_amt is never interpreted modulo anything other than WIDTH.
- out_zero is computed in the final stage register, aligned with out_data.
- Stage registers for an invalid slot may hold stale values. Only out_* when out_valid=1 is architecturally defined, except for the reset values above.
- Simultaneous accept and emit in the same cycle is legal: the pipeline advances once.

Test Plan:
- Basic ops, WIDTH=32, B=2: SRL 0x80000001>>31 → 0x00000001; SRA 0x80000000>>4 → 0xF8000000; SRL 0x80000000>>4 → 0x08000000. Each result appears exactly 3 cycles after acceptance, with out_zero=0.
- ROR and SLL: ROR 0x000000F1 by 4 → 0x1000000F. SLL 0x00000001 by 31 → 0x80000000. SLL 0xFFFFFFFF by 0 → 0xFFFFFFFF. SRL 0x0000000F by 4 → 0x00000000 with out_zero=1.
- Streaming: issue 8 back-to-back requests with tags 0..7 and out_ready held high. Required: 8 consecutive out_valid cycles starting 3 cycles after the first accept, tags in order 0..7.
- Back-pressure: stream 4 requests, drop out_ready for 5 cycles after the first result appears. Required: in_ready=0 throughout the stall; out_data and out_tag hold; after release, the remaining results emerge in order with none lost or duplicated.
- Reset mid-flight: accept 2 requests, assert rst for 1 cycle before either emerges. Required: out_valid=0, out_data=0 and in_ready=1 the next cycle; neither dropped request ever appears.
- Parameter sweep: WIDTH=8 with B=1 (LAT=3) and WIDTH=64 with B=3 (LAT=2). Compare against a reference model over 1000 random ops/amounts, with latency checked per configuration.
